// File: rtl/coord_pair_test.sv
// Pairs consecutive RNG samples into (x, y) and flags x^2 + y^2 < 1.
// Result appears three cycles after the y sample is accepted.
module coord_pair_test #(
  parameter int IP_BIT_WIDTH = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IP_BIT_WIDTH-1:0] rand_num,
  input  logic                    rand_valid,
  input  logic                    flush,
  output logic                    coord_valid_out,
  output logic                    op_lt_1_out,
  output logic                    pair_phase
);

  localparam int W = IP_BIT_WIDTH;
  localparam logic [2*W:0] LIM = {1'b1, {(2*W){1'b0}}};

  typedef enum logic {
    WAIT_X = 1'b0,
    WAIT_Y = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_take_x;
  logic   w_launch;

  logic [W-1:0]   r_x_hold;
  logic [W-1:0]   r_xr;
  logic [W-1:0]   r_yr;
  logic           r_v1;
  logic [2*W-1:0] r_xsq;
  logic [2*W-1:0] r_ysq;
  logic           r_v2;
  logic           r_vout;
  logic           r_hit;
  logic [2*W:0]   w_sum;
  logic           w_hit;

  always_comb begin
    w_state_nxt = r_state;
    w_take_x    = 1'b0;
    w_launch    = 1'b0;
    if (flush) begin
      w_state_nxt = WAIT_X;
    end else if (rand_valid) begin
      unique case (r_state)
        WAIT_X: begin
          w_take_x    = 1'b1;
          w_state_nxt = WAIT_Y;
        end
        WAIT_Y: begin
          w_launch    = 1'b1;
          w_state_nxt = WAIT_X;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= WAIT_X;
      r_x_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_x_hold <= '0;
      end else if (w_take_x) begin
        r_x_hold <= rand_num;
      end
    end
  end

  // Full-width sum; the carry into bit 2W is exactly the "not below 1" case
  assign w_sum = {1'b0, r_xsq} + {1'b0, r_ysq};
  assign w_hit = (w_sum < LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xr   <= '0;
      r_yr   <= '0;
      r_v1   <= 1'b0;
      r_xsq  <= '0;
      r_ysq  <= '0;
      r_v2   <= 1'b0;
      r_vout <= 1'b0;
      r_hit  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_xr <= r_x_hold;
        r_yr <= rand_num;
      end
      r_v1   <= w_launch;
      r_xsq  <= {{W{1'b0}}, r_xr} * {{W{1'b0}}, r_xr};
      r_ysq  <= {{W{1'b0}}, r_yr} * {{W{1'b0}}, r_yr};
      r_v2   <= r_v1 & ~flush;
      r_vout <= r_v2 & ~flush;
      r_hit  <= r_v2 & ~flush & w_hit;
    end
  end

  assign coord_valid_out = r_vout;
  assign op_lt_1_out     = r_hit;
  assign pair_phase      = (r_state == WAIT_Y);

endmodule
